// File: rtl/result_writeback_arbiter.sv
// Shares the result-select/writeback stage between the pipelined add/mul
// path and the iterative div/sqrt unit. One registered output slot with
// valid/ready backpressure; div gets forced priority after STARVE_LIMIT
// consecutive lost arbitrations.
module result_writeback_arbiter #(
    parameter  int unsigned STARVE_LIMIT = 4,
    parameter  int unsigned FRAC_WIDTH   = 32,
    parameter  int unsigned EXP_WIDTH    = 10,
    parameter  int unsigned TAG_WIDTH    = 4,
    localparam int unsigned PW           = 4 + 3 + EXP_WIDTH + FRAC_WIDTH + TAG_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pipe_valid,
    output logic          pipe_ready,
    input  logic [PW-1:0] pipe_data,
    input  logic          div_valid,
    output logic          div_ready,
    input  logic [PW-1:0] div_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data,
    output logic          out_src
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        PIPE_PRI  = 1'b0,
        DIV_FORCE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   starve_cnt;
    logic [CNT_W-1:0]   starve_nxt;
    logic [CNT_W-1:0]   starve_inc;
    logic               accept;
    logic               grant_pipe;
    logic               grant_div;

    // State and starvation counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PIPE_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Grant selection, ready outputs, starvation tracking and next state
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        grant_pipe = 1'b0;
        grant_div  = 1'b0;
        accept     = !out_valid || out_ready;
        starve_inc = CNT_W'(starve_cnt + CNT_W'(1));

        // No handshake is acknowledged while reset is asserted
        if (!reset && accept) begin
            case (state)
                PIPE_PRI: begin
                    if (pipe_valid)     grant_pipe = 1'b1;
                    else if (div_valid) grant_div  = 1'b1;
                end
                DIV_FORCE: begin
                    if (div_valid)      grant_div  = 1'b1;
                end
                default: ;
            endcase
        end

        pipe_ready = grant_pipe;
        div_ready  = grant_div;

        // A stalled slot grants nobody, so the counter simply holds then
        if (!div_valid || grant_div) begin
            starve_nxt = '0;
        end else if (grant_pipe) begin
            starve_nxt = starve_inc;
        end

        case (state)
            PIPE_PRI: begin
                if (div_valid && grant_pipe && (starve_inc == CNT_W'(STARVE_LIMIT)))
                    state_nxt = DIV_FORCE;
            end
            DIV_FORCE: begin
                // Leave on the div handshake, or if div dropped valid anyway
                if (!div_valid || grant_div)
                    state_nxt = PIPE_PRI;
            end
            default: state_nxt = PIPE_PRI;
        endcase
    end

    // Output slot: load on a handshake, drain when consumed without reload
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (grant_pipe) begin
            out_valid <= 1'b1;
            out_data  <= pipe_data;
            out_src   <= 1'b0;
        end else if (grant_div) begin
            out_valid <= 1'b1;
            out_data  <= div_data;
            out_src   <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_result_writeback_arbiter.sv
// Randomized bench for result_writeback_arbiter against a behavioural model
// that tracks the slot contents and how many grants div has lost in a row.
module tb_result_writeback_arbiter;

    localparam int unsigned SL = 4;
    localparam int unsigned FW = 32;
    localparam int unsigned EW = 10;
    localparam int unsigned TW = 4;
    localparam int unsigned PW = 4 + 3 + EW + FW + TW;

    logic          clk = 1'b0;
    logic          reset;
    logic          pipe_valid;
    logic          pipe_ready;
    logic [PW-1:0] pipe_data;
    logic          div_valid;
    logic          div_ready;
    logic [PW-1:0] div_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic          out_src;

    always #5 clk = ~clk;

    result_writeback_arbiter #(
        .STARVE_LIMIT (SL),
        .FRAC_WIDTH   (FW),
        .EXP_WIDTH    (EW),
        .TAG_WIDTH    (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_valid (pipe_valid),
        .pipe_ready (pipe_ready),
        .pipe_data  (pipe_data),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_data   (div_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src)
    );

    // Reference model state
    bit            m_ov;
    logic [PW-1:0] m_od;
    bit            m_src;
    int            m_lost;      // consecutive grants div has lost while waiting

    bit            pend_pipe_drop;
    bit            pend_div_drop;
    int            n_vec;
    int            n_err;
    int            div_wins;

    // Compare one observed value against its expectation
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rand_payload();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return PW'(r);
    endfunction

    // One clock cycle: drive at negedge, check before posedge, update model at posedge
    task automatic step(input bit rst, input int p_pv, input int p_dv, input int p_or,
                        input int pipe_tag);
        bit accept, forced, e_pr, e_dr;
        @(negedge clk);
        if (pend_pipe_drop) pipe_valid = 1'b0;
        if (pend_div_drop)  div_valid  = 1'b0;
        pend_pipe_drop = 1'b0;
        pend_div_drop  = 1'b0;
        reset = rst;
        if (!pipe_valid && ($urandom_range(99) < p_pv)) begin
            pipe_valid = 1'b1;
            pipe_data  = rand_payload();
            if (pipe_tag >= 0) pipe_data[TW-1:0] = TW'(pipe_tag);
        end
        if (!div_valid && ($urandom_range(99) < p_dv)) begin
            div_valid = 1'b1;
            div_data  = rand_payload();
        end
        out_ready = ($urandom_range(99) < p_or);
        #1;
        accept = !m_ov || out_ready;
        forced = (m_lost >= int'(SL));
        e_pr   = !rst && accept && pipe_valid && !forced;
        e_dr   = !rst && accept && div_valid && (forced || !pipe_valid);
        check("pipe_ready", 64'(pipe_ready), 64'(e_pr));
        check("div_ready",  64'(div_ready),  64'(e_dr));
        check("out_valid",  64'(out_valid),  64'(m_ov));
        check("out_data",   64'(out_data),   64'(m_od));
        check("out_src",    64'(out_src),    64'(m_src));
        if (div_ready) div_wins++;
        @(posedge clk);
        if (rst) begin
            m_ov = 1'b0; m_od = '0; m_src = 1'b0; m_lost = 0;
        end else begin
            if (e_pr) begin
                m_ov = 1'b1; m_od = pipe_data; m_src = 1'b0;
            end else if (e_dr) begin
                m_ov = 1'b1; m_od = div_data; m_src = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (!div_valid || e_dr) m_lost = 0;
            else if (e_pr)          m_lost = m_lost + 1;
            pend_pipe_drop = e_pr;
            pend_div_drop  = e_dr;
        end
    endtask

    initial begin
        reset = 1'b1; pipe_valid = 1'b0; div_valid = 1'b0; out_ready = 1'b0;
        pipe_data = '0; div_data = '0;
        m_ov = 1'b0; m_od = '0; m_src = 1'b0; m_lost = 0;
        pend_pipe_drop = 1'b0; pend_div_drop = 1'b0;
        n_vec = 0; n_err = 0; div_wins = 0;

        // Reset with both sources valid, then release
        repeat (2) step(1'b1, 100, 100, 100, -1);
        repeat (3) step(1'b0, 100, 100, 100, -1);

        // Div-only streaming
        repeat (2) step(1'b1, 0, 0, 100, -1);
        repeat (6) step(1'b0, 0, 100, 100, -1);

        // Starvation pattern: 4 pipe then 1 div, repeating
        step(1'b1, 0, 0, 100, -1);
        div_wins = 0;
        repeat (25) step(1'b0, 100, 100, 100, -1);
        check("starve_div_wins", 64'(div_wins), 64'(25 / (SL + 1)));

        // Backpressure with both valid, then resume
        repeat (3) step(1'b0, 100, 100, 0, -1);
        repeat (6) step(1'b0, 100, 100, 100, -1);

        // Drain and reload with a known tag
        step(1'b0, 100, 0, 100, -1);
        step(1'b0, 100, 0, 100, 7);
        step(1'b0, 0, 0, 0, -1);
        check("reload_tag", 64'(out_data[TW-1:0]), 64'(7));

        // Reset while div has forced priority and the slot is full
        step(1'b1, 0, 0, 100, -1);
        repeat (4) step(1'b0, 100, 100, 100, -1);
        step(1'b1, 100, 100, 0, -1);
        repeat (4) step(1'b0, 100, 100, 100, -1);

        // Mixed random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) < 2), 60, 50, 70, -1);
        end
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 90, 90, 40, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
